// File: rtl/seq_div_16bit.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned
// per request, with a start/busy/done handshake. Divide-by-zero finishes at once.
module seq_div_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sign,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dbz,
   output logic             ofl
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;          // partial remainder
   logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qneg_q, qneg_d;    // quotient must be negated at the end
   logic             rneg_q, rneg_d;    // remainder must be negated at the end
   logic             oflp_q, oflp_d;    // most-negative / -1 seen at capture
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             ofl_q, ofl_d;

   logic [WIDTH-1:0] shift_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] r_next_s;
   logic [WIDTH-1:0] q_next_s;

   // Two's-complement negation at operand width.
   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   // Magnitude of an operand: only negative signed values get negated.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? neg_f(x) : x;
   endfunction

   // R never reaches bit WIDTH-1 before the last step, so dropping R's MSB is safe.
   assign shift_s  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign trial_s  = {1'b0, shift_s} - {1'b0, d_q};
   assign r_next_s = trial_s[WIDTH] ? shift_s : trial_s[WIDTH-1:0];
   assign q_next_s = {q_q[WIDTH-2:0], ~trial_s[WIDTH]};

   // Next-state and datapath control for the IDLE/RUN/FIN sequencer.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      oflp_d  = oflp_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ofl_d   = ofl_q;
      case (state_q)
         IDLE, FIN: begin
            if (start) begin
               if (b == {WIDTH{1'b0}}) begin
                  state_d = FIN;
                  quot_d  = {WIDTH{1'b1}};
                  rem_d   = a;
                  dbz_d   = 1'b1;
                  ofl_d   = 1'b0;
               end else begin
                  state_d = RUN;
                  r_d     = {WIDTH{1'b0}};
                  q_d     = mag_f(a, sign);
                  d_d     = mag_f(b, sign);
                  qneg_d  = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rneg_d  = sign & a[WIDTH-1];
                  oflp_d  = sign && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            r_d   = r_next_s;
            q_d   = q_next_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIN;
               quot_d  = qneg_q ? neg_f(q_next_s) : q_next_s;
               rem_d   = rneg_q ? neg_f(r_next_s) : r_next_s;
               dbz_d   = 1'b0;
               ofl_d   = oflp_q;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any division in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= {WIDTH{1'b0}};
         q_q     <= {WIDTH{1'b0}};
         d_q     <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         oflp_q  <= 1'b0;
         quot_q  <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         dbz_q   <= 1'b0;
         ofl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         oflp_q  <= oflp_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ofl_q   <= ofl_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == FIN);
   assign quot = quot_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;
   assign ofl  = ofl_q;

endmodule
